// File: rtl/caesar_pkg.sv
// Shared constants and types for the Caesar-digit link.
// Holds the Johnson symbol table, the blank code and the decoder state type.
package caesar_pkg;

    localparam int NUM_DIGITS = 10;

    localparam logic [4:0] CODE_BLANK = 5'b01010;
    localparam logic [3:0] DIGIT_ERR  = 4'hF;

    localparam logic [4:0] JOHNSON [NUM_DIGITS] = '{
        5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
        5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001
    };

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dec_state_t;

endpackage

// File: rtl/caesar_johnson_dec.sv
// Combinational Johnson symbol classifier.
// Maps a 5-bit code to its digit value and flags legal and blank codes.
module caesar_johnson_dec
    import caesar_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] value,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        value = '0;
        legal = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code == JOHNSON[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
        end
    end

    assign blank = (code == CODE_BLANK);

endmodule

// File: rtl/caesar_decoder.sv
// Receive side of the Caesar-digit link: validates Johnson symbols,
// removes the key modulo 10 and presents the result on a one-entry output stage.
module caesar_decoder
    import caesar_pkg::*;
#(
    parameter int KEY   = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_code,
    input  logic             key_load,
    input  logic [3:0]       key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic             out_err,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    dec_state_t state;
    logic [3:0] key;
    logic [3:0] value;
    logic       legal;
    logic       blank;
    logic       accept;
    logic [4:0] diff;
    logic [3:0] plain;

    caesar_johnson_dec u_jdec (
        .code  (in_code),
        .value (value),
        .legal (legal),
        .blank (blank)
    );

    assign in_ready = reset & ((state == EMPTY) | out_ready);
    assign accept   = in_valid & in_ready;

    // value + 10 - key lies in 1..19, so one conditional subtract suffices
    assign diff  = {1'b0, value} + 5'd10 - {1'b0, key};
    assign plain = (diff >= 5'd10) ? 4'(diff - 5'd10) : diff[3:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            key       <= 4'(KEY);
            out_valid <= 1'b0;
            out_digit <= '0;
            out_err   <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            if (key_load && key_in <= 4'd9)
                key <= key_in;

            if (accept && blank) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
            end else if (accept) begin
                state     <= FULL;
                out_valid <= 1'b1;
                out_err   <= ~legal;
                out_digit <= legal ? plain : DIGIT_ERR;
                if (legal) begin
                    if (ok_cnt != '1)
                        ok_cnt <= ok_cnt + 1'b1;
                end else begin
                    if (err_cnt != '1)
                        err_cnt <= err_cnt + 1'b1;
                end
            end else if (state == FULL && out_ready) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
